// File: rtl/ctrl_pkg.sv
// Shared decode vocabulary for the RV32IM control unit: ALU operation codes, base opcodes,
// the per-instruction control bundle and the multi-cycle op classification helpers.
package ctrl_pkg;

    typedef enum logic [4:0] {
        ALU_NOP    = 5'd0,
        ALU_ADD    = 5'd1,
        ALU_SUB    = 5'd2,
        ALU_XOR    = 5'd3,
        ALU_OR     = 5'd4,
        ALU_AND    = 5'd5,
        ALU_SLL    = 5'd6,
        ALU_SRL    = 5'd7,
        ALU_SLA    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_SLT    = 5'd10,
        ALU_SLTU   = 5'd11,
        ALU_AUI    = 5'd12,
        ALU_AUIPC  = 5'd13,
        ALU_MUL    = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_MULH   = 5'd16,
        ALU_MULHSU = 5'd17,
        ALU_MULHU  = 5'd18,
        ALU_DIVU   = 5'd19,
        ALU_REM    = 5'd20,
        ALU_REMU   = 5'd21
    } alu_op_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        alu_op_t    alu_op;
        logic       reg_reg;
        logic       load;
        logic       store;
        logic       branch;
        logic       jump;
        logic       illegal;
        logic [4:0] rd;
    } ctrl_t;

    typedef enum logic {
        MC_IDLE,
        MC_BUSY
    } mc_state_t;

    function automatic logic is_mul(input alu_op_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic is_div(input alu_op_t op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/mc_sequencer.sv
// Multi-cycle MUL/DIV sequencer: counts the EX occupancy of an M-extension op and
// signals when its result is ready; abort drops any operation in flight.
module mc_sequencer
    import ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start_mul,
    input  logic start_div,
    input  logic abort,
    output logic busy,
    output logic done
);

    localparam logic             MUL_ONE = (MUL_LATENCY == 1);
    localparam logic             DIV_ONE = (DIV_LATENCY == 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY - 1);

    mc_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             single;

    // Starts arrive on the handoff edge, so the op's first EX cycle already counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= MC_IDLE;
            cnt    <= '0;
            single <= 1'b0;
        end else if (abort) begin
            state  <= MC_IDLE;
            cnt    <= '0;
            single <= 1'b0;
        end else begin
            single <= 1'b0;
            if ((start_mul && MUL_ONE) || (start_div && DIV_ONE)) begin
                state  <= MC_IDLE;
                single <= 1'b1;
            end else if (start_mul) begin
                state <= MC_BUSY;
                cnt   <= MUL_CNT;
            end else if (start_div) begin
                state <= MC_BUSY;
                cnt   <= DIV_CNT;
            end else if (state == MC_BUSY) begin
                if (cnt == '0) begin
                    state <= MC_IDLE;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

    assign busy = (state == MC_BUSY);
    assign done = ~abort & (single | (busy && (cnt == '0)));

endmodule

// File: rtl/pipelined_control_unit.sv
// RV32IM decode/control with EX/MEM/WB control pipeline and multi-cycle MUL/DIV stalling.
// Define BRANCH_JUMP_EN to decode BRANCH/JAL/JALR; otherwise they decode as illegal.
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 5,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [31:0]         id_instr,
    output logic                id_ready,
    input  logic                stall_in,
    input  logic                flush,
    output logic                ex_valid,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_reg_reg,
    output logic                ex_branch,
    output logic                ex_jump,
    output logic [2:0]          ex_funct3,
    output logic                ex_illegal,
    output logic                ex_mc_done,
    output logic                mem_valid,
    output logic                mem_load,
    output logic                mem_store,
    output logic                wb_valid,
    output logic                wb_en,
    output logic [4:0]          wb_rd,
    output logic                mc_busy
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    ctrl_t      dec;
    logic       legal;
    logic       handoff;
    logic       unused_bits;

    assign opcode      = id_instr[6:0];
    assign funct3      = id_instr[14:12];
    assign funct7      = id_instr[31:25];
    assign unused_bits = ^id_instr[24:15];

    always_comb begin
        dec    = '0;
        dec.rd = id_instr[11:7];
        legal  = 1'b1;
        case (opcode)
            OPC_LOAD: begin
                dec.alu_op = ALU_ADD;
                dec.load   = 1'b1;
                legal      = !(funct3 inside {3'b011, 3'b110, 3'b111});
            end
            OPC_STORE: begin
                dec.alu_op = ALU_ADD;
                dec.store  = 1'b1;
                dec.rd     = '0;
                legal      = (funct3 < 3'b011);
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'b000: dec.alu_op = ALU_ADD;
                    3'b001: begin
                        dec.alu_op = ALU_SLL;
                        legal      = (funct7 == 7'h00);
                    end
                    3'b010: dec.alu_op = ALU_SLT;
                    3'b011: dec.alu_op = ALU_SLTU;
                    3'b100: dec.alu_op = ALU_XOR;
                    3'b101: begin
                        dec.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                        legal      = ((funct7 & 7'b1011111) == 7'h00);
                    end
                    3'b110: dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                dec.reg_reg = 1'b1;
                case ({funct7[5], funct7[0], funct3})
                    5'b00_000: dec.alu_op = ALU_ADD;
                    5'b00_001: dec.alu_op = ALU_SLL;
                    5'b00_010: dec.alu_op = ALU_SLT;
                    5'b00_011: dec.alu_op = ALU_SLTU;
                    5'b00_100: dec.alu_op = ALU_XOR;
                    5'b00_101: dec.alu_op = ALU_SRL;
                    5'b00_110: dec.alu_op = ALU_OR;
                    5'b00_111: dec.alu_op = ALU_AND;
                    5'b10_000: dec.alu_op = ALU_SUB;
                    5'b10_101: dec.alu_op = ALU_SRA;
                    5'b01_000: dec.alu_op = ALU_MUL;
                    5'b01_001: dec.alu_op = ALU_MULH;
                    5'b01_010: dec.alu_op = ALU_MULHSU;
                    5'b01_011: dec.alu_op = ALU_MULHU;
                    5'b01_100: dec.alu_op = ALU_DIV;
                    5'b01_101: dec.alu_op = ALU_DIVU;
                    5'b01_110: dec.alu_op = ALU_REM;
                    5'b01_111: dec.alu_op = ALU_REMU;
                    default:   legal      = 1'b0;
                endcase
                // The map key ignores funct7 bits other than [5] and [0]; those must be zero.
                if ((funct7 & 7'b1011110) != 7'h00) begin
                    legal = 1'b0;
                end
            end
            OPC_LUI:   dec.alu_op = ALU_AUI;
            OPC_AUIPC: dec.alu_op = ALU_AUIPC;
`ifdef BRANCH_JUMP_EN
            OPC_BRANCH: begin
                dec.alu_op  = ALU_SUB;
                dec.reg_reg = 1'b1;
                dec.branch  = 1'b1;
                dec.rd      = '0;
                legal       = !(funct3 inside {3'b010, 3'b011});
            end
            OPC_JAL: begin
                dec.alu_op = ALU_AUIPC;
                dec.jump   = 1'b1;
            end
            OPC_JALR: begin
                dec.alu_op = ALU_ADD;
                dec.jump   = 1'b1;
                legal      = (funct3 == 3'b000);
            end
`else
            OPC_BRANCH, OPC_JAL, OPC_JALR: legal = 1'b0;
`endif
            default: legal = 1'b0;
        endcase
        if (!legal || (id_instr[1:0] != 2'b11)) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // EX advances exactly when ID may hand over; the sequencer holds it until done.
    assign id_ready = ~stall_in & ~(mc_busy & ~ex_mc_done);
    assign handoff  = id_valid & id_ready & ~flush;

    mc_sequencer #(
        .MUL_LATENCY (MUL_LATENCY),
        .DIV_LATENCY (DIV_LATENCY),
        .CNT_W       (CNT_W)
    ) u_mc_sequencer (
        .clk       (clk),
        .reset     (reset),
        .start_mul (handoff & is_mul(dec.alu_op)),
        .start_div (handoff & is_div(dec.alu_op)),
        .abort     (flush),
        .busy      (mc_busy),
        .done      (ex_mc_done)
    );

    ctrl_t      ex_ctrl;
    logic       mem_illegal;
    logic       mem_branch;
    logic [4:0] mem_rd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_funct3 <= '0;
        end else if (flush) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_funct3 <= '0;
        end else if (id_ready) begin
            ex_valid  <= id_valid;
            ex_ctrl   <= id_valid ? dec : '0;
            ex_funct3 <= id_valid ? funct3 : 3'b000;
        end
    end

    // A held or flushed EX feeds a bubble forward rather than duplicating or leaking its op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid   <= 1'b0;
            mem_load    <= 1'b0;
            mem_store   <= 1'b0;
            mem_illegal <= 1'b0;
            mem_branch  <= 1'b0;
            mem_rd      <= '0;
        end else if (id_ready && !flush) begin
            mem_valid   <= ex_valid;
            mem_load    <= ex_ctrl.load;
            mem_store   <= ex_ctrl.store;
            mem_illegal <= ex_ctrl.illegal;
            mem_branch  <= ex_ctrl.branch;
            mem_rd      <= ex_ctrl.rd;
        end else begin
            mem_valid   <= 1'b0;
            mem_load    <= 1'b0;
            mem_store   <= 1'b0;
            mem_illegal <= 1'b0;
            mem_branch  <= 1'b0;
            mem_rd      <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid <= 1'b0;
            wb_en    <= 1'b0;
            wb_rd    <= '0;
        end else begin
            wb_valid <= mem_valid;
            wb_en    <= mem_valid & ~mem_illegal & ~mem_store & ~mem_branch & (mem_rd != 5'd0);
            wb_rd    <= mem_rd;
        end
    end

    assign ex_alu_op  = ALU_OP_W'(ex_ctrl.alu_op);
    assign ex_reg_reg = ex_ctrl.reg_reg;
    assign ex_illegal = ex_ctrl.illegal;

`ifdef BRANCH_JUMP_EN
    assign ex_branch = ex_ctrl.branch;
    assign ex_jump   = ex_ctrl.jump;
`else
    logic unused_jump;
    assign ex_branch   = 1'b0;
    assign ex_jump     = 1'b0;
    assign unused_jump = ex_ctrl.jump;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: instruction-level reference model checked every cycle,
// plus directed literal checks. Honours BRANCH_JUMP_EN the same way as the design.
module tb_pipelined_control_unit;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        id_ready;
    logic        stall_in;
    logic        flush;
    logic        ex_valid;
    logic [4:0]  ex_alu_op;
    logic        ex_reg_reg;
    logic        ex_branch;
    logic        ex_jump;
    logic [2:0]  ex_funct3;
    logic        ex_illegal;
    logic        ex_mc_done;
    logic        mem_valid;
    logic        mem_load;
    logic        mem_store;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic        mc_busy;

    always #5 clk = ~clk;

    pipelined_control_unit #(
        .ALU_OP_W    (5),
        .MUL_LATENCY (MUL_LAT),
        .DIV_LATENCY (DIV_LAT),
        .CNT_W       (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_ready   (id_ready),
        .stall_in   (stall_in),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_alu_op  (ex_alu_op),
        .ex_reg_reg (ex_reg_reg),
        .ex_branch  (ex_branch),
        .ex_jump    (ex_jump),
        .ex_funct3  (ex_funct3),
        .ex_illegal (ex_illegal),
        .ex_mc_done (ex_mc_done),
        .mem_valid  (mem_valid),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .wb_valid   (wb_valid),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .mc_busy    (mc_busy)
    );

    typedef struct {
        int alu_op;
        bit reg_reg;
        bit load;
        bit store;
        bit branch;
        bit jump;
        bit illegal;
        int rd;
        int funct3;
        int lat;
    } rec_t;

    typedef struct {
        bit   valid;
        rec_t r;
        int   rem;
    } slot_t;

    slot_t m_ex, m_mem, m_wb;
    int    tests = 0;
    int    fails = 0;

    // Reference decode from the ISA tables: what each instruction must mean in EX.
    function automatic rec_t ref_decode(input logic [31:0] ins);
        rec_t       r;
        int         alu_f3 [8] = '{1, 6, 10, 11, 3, 7, 4, 5};
        int         mext   [8] = '{14, 16, 17, 18, 15, 19, 20, 21};
        logic [6:0] f7;
        logic [2:0] f3;
        bit         ok;
        f7 = ins[31:25];
        f3 = ins[14:12];
        ok = 1'b1;
        r  = '{default: 0};
        r.funct3 = int'(f3);
        case (ins[6:0])
            7'h03: begin r.alu_op = 1; r.load = 1; r.rd = int'(ins[11:7]); ok = !(f3 inside {3, 6, 7}); end
            7'h23: begin r.alu_op = 1; r.store = 1; ok = (f3 < 3); end
            7'h13: begin
                r.alu_op = alu_f3[f3];
                r.rd     = int'(ins[11:7]);
                if (f3 == 3'd5 && f7[5]) r.alu_op = 9;
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            end
            7'h33: begin
                r.reg_reg = 1;
                r.rd      = int'(ins[11:7]);
                if (f7 == 7'h00) r.alu_op = alu_f3[f3];
                else if (f7 == 7'h01) begin
                    r.alu_op = mext[f3];
                    r.lat    = f3[2] ? DIV_LAT : MUL_LAT;
                end
                else if (f7 == 7'h20 && f3 == 3'd0) r.alu_op = 2;
                else if (f7 == 7'h20 && f3 == 3'd5) r.alu_op = 9;
                else ok = 1'b0;
            end
            7'h37: begin r.alu_op = 12; r.rd = int'(ins[11:7]); end
            7'h17: begin r.alu_op = 13; r.rd = int'(ins[11:7]); end
`ifdef BRANCH_JUMP_EN
            7'h63: begin r.alu_op = 2; r.reg_reg = 1; r.branch = 1; ok = !(f3 inside {2, 3}); end
            7'h6F: begin r.alu_op = 13; r.jump = 1; r.rd = int'(ins[11:7]); end
            7'h67: begin r.alu_op = 1; r.jump = 1; r.rd = int'(ins[11:7]); ok = (f3 == 3'd0); end
`endif
            default: ok = 1'b0;
        endcase
        if (!ok || ins[1:0] != 2'b11) begin
            r         = '{default: 0};
            r.illegal = 1;
            r.funct3  = int'(f3);
        end
        return r;
    endfunction

    function automatic bit m_busy();
        return m_ex.valid && m_ex.r.lat > 1 && m_ex.rem >= 1;
    endfunction

    function automatic bit m_done();
        return m_ex.valid && m_ex.r.lat >= 1 && m_ex.rem == 1 && !flush;
    endfunction

    function automatic bit m_ready();
        return !stall_in && !(m_busy() && !m_done());
    endfunction

    task automatic clear_model();
        m_ex  = '{valid: 0, r: '{default: 0}, rem: 0};
        m_mem = m_ex;
        m_wb  = m_ex;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input bit v, input logic [31:0] ins, input bit st, input bit fl);
        id_valid = v;
        id_instr = ins;
        stall_in = st;
        flush    = fl;
    endtask

    task automatic check_output();
        rec_t e, w;
        e = m_ex.valid ? m_ex.r : '{default: 0};
        w = m_wb.valid ? m_wb.r : '{default: 0};
        cmp("ex_valid",   ex_valid,   m_ex.valid);
        cmp("ex_alu_op",  ex_alu_op,  e.alu_op);
        cmp("ex_reg_reg", ex_reg_reg, e.reg_reg);
        cmp("ex_branch",  ex_branch,  e.branch);
        cmp("ex_jump",    ex_jump,    e.jump);
        cmp("ex_funct3",  ex_funct3,  e.funct3);
        cmp("ex_illegal", ex_illegal, e.illegal);
        cmp("ex_mc_done", ex_mc_done, m_done());
        cmp("mc_busy",    mc_busy,    m_busy());
        cmp("id_ready",   id_ready,   m_ready());
        cmp("mem_valid",  mem_valid,  m_mem.valid);
        cmp("mem_load",   mem_load,   m_mem.valid && m_mem.r.load);
        cmp("mem_store",  mem_store,  m_mem.valid && m_mem.r.store);
        cmp("wb_valid",   wb_valid,   m_wb.valid);
        cmp("wb_en",      wb_en,      m_wb.valid && !w.illegal && !w.store && !w.branch && w.rd != 0);
        cmp("wb_rd",      wb_rd,      w.rd);
    endtask

    task automatic model_step();
        bit rdy;
        rdy  = m_ready();
        m_wb = m_mem;
        if (flush) begin
            m_mem.valid = 0;
            m_mem.r     = '{default: 0};
            m_ex.valid  = 0;
            m_ex.r      = '{default: 0};
            m_ex.rem    = 0;
        end else if (rdy) begin
            m_mem = m_ex;
            if (id_valid) begin
                m_ex.valid = 1;
                m_ex.r     = ref_decode(id_instr);
                m_ex.rem   = m_ex.r.lat;
            end else begin
                m_ex.valid = 0;
                m_ex.r     = '{default: 0};
                m_ex.rem   = 0;
            end
        end else begin
            m_mem.valid = 0;
            m_mem.r     = '{default: 0};
            if (m_ex.rem > 0) m_ex.rem--;
        end
    endtask

    task automatic tick(input bit v, input logic [31:0] ins, input bit st, input bit fl, output bit acc);
        @(negedge clk);
        apply_stimulus(v, ins, st, fl);
        #2;
        check_output();
        acc = v && m_ready() && !fl;
        model_step();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(0, 32'h0, 0, 0, acc);
    endtask

    task automatic send(input logic [31:0] ins);
        bit acc;
        acc = 0;
        for (int i = 0; i < 64 && !acc; i++) tick(1, ins, 0, 0, acc);
        cmp("send_accept", acc, 1);
    endtask

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_DIV   = 32'h027342B3;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_LW    = 32'h0080A203;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_SRAI  = 32'h4030D113;
    localparam logic [31:0] I_SUB   = 32'h40628233;
    localparam logic [31:0] I_LUI   = 32'h123453B7;
    localparam logic [31:0] I_MUL   = 32'h02A48433;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_JALR  = 32'h00008067;
    localparam logic [31:0] I_CMPR  = 32'h00000001;

    initial begin
        int busy_cnt, done_cnt, done_at;
        bit acc;
        clear_model();
        apply_stimulus(0, 32'h0, 0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        cmp("rst_ex_valid",  ex_valid,  0);
        cmp("rst_ex_alu_op", ex_alu_op, 0);
        cmp("rst_mem_valid", mem_valid, 0);
        cmp("rst_wb_valid",  wb_valid,  0);
        cmp("rst_wb_rd",     wb_rd,     0);
        cmp("rst_mc_busy",   mc_busy,   0);
        @(negedge clk);
        reset = 1'b1;

        // ADD x3,x1,x2
        send(I_ADD);
        idle(1);
        cmp("t1_ex_alu_op",  ex_alu_op,  1);
        cmp("t1_ex_reg_reg", ex_reg_reg, 1);
        idle(2);
        cmp("t1_wb_en", wb_en, 1);
        cmp("t1_wb_rd", wb_rd, 3);

        // DIV x5,x6,x7 occupying EX for DIV_LAT cycles
        send(I_DIV);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -10;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (mc_busy) busy_cnt++;
            if (ex_mc_done) begin done_cnt++; done_at = i; end
            if (i == 0)  cmp("t2_ex_alu_op", ex_alu_op, 15);
            if (i == 3)  cmp("t2_id_ready_busy", id_ready, 0);
            if (i == 31) cmp("t2_done_cycle", ex_mc_done, 1);
            if (i == done_at + 2) begin
                cmp("t2_wb_rd", wb_rd, 5);
                cmp("t2_wb_en", wb_en, 1);
            end
        end
        cmp("t2_busy_cycles", busy_cnt, 32);
        cmp("t2_done_pulses", done_cnt, 1);

        // All-zero word is illegal
        send(32'h0);
        idle(1);
        cmp("t3_ex_illegal", ex_illegal, 1);
        cmp("t3_ex_alu_op",  ex_alu_op,  0);
        cmp("t3_mc_busy",    mc_busy,    0);
        idle(2);
        cmp("t3_wb_valid", wb_valid, 1);
        cmp("t3_wb_en",    wb_en,    0);

        // SW then LW
        send(I_SW);
        send(I_LW);
        cmp("t4_ex_alu_op", ex_alu_op, 1);
        idle(1);
        cmp("t4_mem_store", mem_store, 1);
        cmp("t4_mem_load",  mem_load,  0);
        idle(1);
        cmp("t4_wb_en",    wb_en,    0);
        cmp("t4_lw_load",  mem_load, 1);

        // Flush in the fifth EX cycle of a DIV
        send(I_DIV);
        idle(4);
        tick(0, 32'h0, 0, 1, acc);
        idle(1);
        cmp("t5_mc_busy",  mc_busy,  0);
        cmp("t5_ex_valid", ex_valid, 0);
        done_cnt = 0;
        for (int i = 0; i < 36; i++) begin
            idle(1);
            if (ex_mc_done) done_cnt++;
        end
        cmp("t5_no_done", done_cnt, 0);

        // BEQ x1,x2
        send(I_BEQ);
        idle(1);
`ifdef BRANCH_JUMP_EN
        cmp("t6_ex_branch", ex_branch, 1);
        cmp("t6_ex_alu_op", ex_alu_op, 2);
`else
        cmp("t6_ex_illegal", ex_illegal, 1);
`endif
        idle(2);
        cmp("t6_wb_en", wb_en, 0);

        // Mixed stream, back-to-back MULs, jumps, compressed word
        send(I_ADDI);
        send(I_SRAI);
        send(I_SUB);
        send(I_LUI);
        send(I_MUL);
        send(I_MUL);
        send(I_DIV);
        send(I_JAL);
        send(I_JALR);
        send(I_CMPR);
        idle(40);

        // External stall holds EX and bubbles MEM; flush beats stall
        send(I_ADD);
        tick(0, 32'h0, 1, 0, acc);
        tick(0, 32'h0, 1, 0, acc);
        cmp("stall_ex_valid",  ex_valid,  1);
        cmp("stall_mem_valid", mem_valid, 0);
        idle(3);
        send(I_ADDI);
        tick(1, I_SUB, 1, 1, acc);
        idle(1);
        cmp("flush_stall_ex_valid", ex_valid, 0);
        idle(3);

        // Asynchronous reset mid-pipeline and mid-DIV
        send(I_ADD);
        send(I_DIV);
        idle(1);
        #1;
        reset = 1'b0;
        #1;
        cmp("t7_ex_valid",  ex_valid,  0);
        cmp("t7_mem_valid", mem_valid, 0);
        cmp("t7_wb_valid",  wb_valid,  0);
        cmp("t7_mc_busy",   mc_busy,   0);
        cmp("t7_wb_en",     wb_en,     0);
        clear_model();
        idle(1);
        @(negedge clk);
        reset = 1'b1;
        send(I_ADD);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
